// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - lsu_state_e    : FSM state encoding
//   - MEM_SIZE_*     : load size codes, shared with the decoder
//   - WBMASK_*       : unshifted store byte masks, shared with the decoder
//   - lsu_misaligned : alignment / legality check for one request
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [3:0] WBMASK_BYTE = 4'b0001;
    localparam logic [3:0] WBMASK_HALF = 4'b0011;
    localparam logic [3:0] WBMASK_WORD = 4'b1111;

    // Illegal encodings (size 11, odd store masks) are reported as
    // misaligned so the core sees a single error path.
    function automatic logic lsu_misaligned(
        input logic       is_load,
        input logic [1:0] mem_size,
        input logic [3:0] wbmask,
        input logic [1:0] lane
    );
        logic bad;
        bad = 1'b1;
        if (is_load) begin
            case (mem_size)
                MEM_SIZE_BYTE: bad = 1'b0;
                MEM_SIZE_HALF: bad = lane[0];
                MEM_SIZE_WORD: bad = (lane != 2'b00);
                default:       bad = 1'b1;
            endcase
        end else begin
            case (wbmask)
                WBMASK_BYTE: bad = 1'b0;
                WBMASK_HALF: bad = lane[0];
                WBMASK_WORD: bad = (lane != 2'b00);
                default:     bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load-data extractor.
//   resp_rdata  in  32  raw memory word
//   lane        in  2   byte offset (addr[1:0])
//   mem_size    in  2   00 byte, 01 half, 10 word
//   is_mem_sign in  1   sign-extend when 1, zero-extend when 0
//   result      out 32  extracted, extended load value
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] resp_rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  mem_size,
    input  logic        is_mem_sign,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = resp_rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? resp_rdata[31:16] : resp_rdata[15:0];
        case (mem_size)
            MEM_SIZE_BYTE: result = {{24{is_mem_sign & byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: result = {{16{is_mem_sign & half_sel[15]}}, half_sel};
            default:       result = resp_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, single-outstanding word-addressed memory bus.
//   clock, reset_n                 clock and asynchronous active-low reset
//   start, is_load, is_store       request strobe and kind (sampled in IDLE)
//   addr, wdata                    byte address, unshifted store data
//   mem_wbmask, mem_size           store mask / load size as decoded
//   is_mem_sign                    sign-extend load data
//   busy, done, rdata, err         status and load result to the core
//   req_valid/ready/we/addr/wdata/wstrb   memory request channel
//   resp_valid, resp_rdata         memory response / write acknowledge
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        mem_wbmask,
    input  logic [1:0]        mem_size,
    input  logic              is_mem_sign,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("lsu: DATA_W must be 32");
        end
    endgenerate

    lsu_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic              load_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [3:0]        req_wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_value;

    logic accept;
    logic misaligned;

    assign accept = (state_q == ST_IDLE) && start && (is_load ^ is_store);

    // The alignment verdict uses exactly the field values being latched on
    // this edge, so the latched request and the REQ/ERR choice always agree.
    assign misaligned = lsu_misaligned(is_load, mem_size, mem_wbmask, addr[1:0]);

    // ERR lasts two cycles: the first lets the error register settle, the
    // second carries the err pulse. This puts err two cycles after start
    // and keeps busy high through the pulse.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = misaligned ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = !err_q;
                state_d = err_q ? ST_IDLE : ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Request fields are captured once and held for the whole transaction,
    // which keeps req_* stable under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_q      <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= 4'b0000;
        end else if (accept) begin
            load_q      <= is_load;
            lane_q      <= addr[1:0];
            size_q      <= mem_size;
            sign_q      <= is_mem_sign;
            req_we_q    <= is_store;
            req_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            req_wdata_q <= wdata << {addr[1:0], 3'b000};
            req_wstrb_q <= is_store ? (mem_wbmask << addr[1:0]) : 4'b0000;
        end
    end

    lsu_align u_align (
        .resp_rdata  (resp_rdata),
        .lane        (lane_q),
        .mem_size    (size_q),
        .is_mem_sign (sign_q),
        .result      (load_value)
    );

    // Stores leave rdata untouched so the last load result stays visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if ((state_q == ST_RESP) && resp_valid && load_q) begin
            rdata_q <= load_value;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign req_valid = (state_q == ST_REQ);
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign rdata     = rdata_q;

endmodule
